// File: rtl/hex_line_formatter.sv
// hex_line_formatter
// Serialises one packed set of ASCII-hex words into a UART byte stream:
// most-significant digit first, words separated by SEP, line closed by
// CR LF (or LF only). One line is captured per transaction; the output
// byte and its valid flag are registered and hold while the sink stalls.

module hex_line_formatter #(
  parameter int         HEX_DIGIT_W = 4,
  parameter int         NUM_WORDS   = 3,
  parameter logic [7:0] SEP         = 8'h20,
  parameter int         EOL_CRLF    = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_WORDS*HEX_DIGIT_W*8-1:0] in_ascii,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [7:0]                        out_data,
  output logic                              busy
);

  localparam int TOTAL_W = NUM_WORDS * HEX_DIGIT_W * 8;
  localparam int WW      = (NUM_WORDS   > 1) ? $clog2(NUM_WORDS)   : 1;
  localparam int DW      = (HEX_DIGIT_W > 1) ? $clog2(HEX_DIGIT_W) : 1;

  localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);
  localparam logic [DW-1:0] TOP_DIGIT = DW'(HEX_DIGIT_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIGIT,
    ST_SEP,
    ST_CR,
    ST_LF
  } state_t;

  state_t             state;
  logic [WW-1:0]      word_idx;
  logic [DW-1:0]      digit_idx;
  logic [TOTAL_W-1:0] cap;

  // Byte (w*HEX_DIGIT_W + d) of a packed line is digit d of word w.
  function automatic logic [7:0] pick(input logic [TOTAL_W-1:0] v,
                                      input logic [31:0]        w,
                                      input logic [31:0]        d);
    return v[(w * HEX_DIGIT_W + d) * 8 +: 8];
  endfunction

  // Ready only when idle and not being reset; independent of in_valid.
  assign in_ready = (state == ST_IDLE) && !rst;
  assign busy     = (state != ST_IDLE);

  // Line sequencer: capture on accept, then advance one byte per accepted output.
  // out_data always holds the byte for the current state, so each transition
  // loads the byte belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      word_idx  <= '0;
      digit_idx <= '0;
      cap       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cap       <= in_ascii;
            word_idx  <= '0;
            digit_idx <= TOP_DIGIT;
            out_data  <= pick(in_ascii, 32'd0, 32'(TOP_DIGIT));
            out_valid <= 1'b1;
            state     <= ST_DIGIT;
          end
        end

        ST_DIGIT: begin
          if (out_ready) begin
            if (digit_idx != '0) begin
              digit_idx <= digit_idx - DW'(1);
              out_data  <= pick(cap, 32'(word_idx), 32'(digit_idx - DW'(1)));
            end else if (word_idx < LAST_WORD) begin
              state    <= ST_SEP;
              out_data <= SEP;
            end else if (EOL_CRLF != 0) begin
              state    <= ST_CR;
              out_data <= 8'h0D;
            end else begin
              state    <= ST_LF;
              out_data <= 8'h0A;
            end
          end
        end

        ST_SEP: begin
          if (out_ready) begin
            state     <= ST_DIGIT;
            word_idx  <= word_idx + WW'(1);
            digit_idx <= TOP_DIGIT;
            out_data  <= pick(cap, 32'(word_idx + WW'(1)), 32'(TOP_DIGIT));
          end
        end

        ST_CR: begin
          if (out_ready) begin
            state    <= ST_LF;
            out_data <= 8'h0A;
          end
        end

        ST_LF: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            word_idx  <= '0;
            digit_idx <= '0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_line_formatter.sv
// Self-checking bench for hex_line_formatter: default-parameter instance
// driven through directed steps with a byte scoreboard, plus a small
// single-word LF-only variant instance.

module tb_hex_line_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_ascii;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;

  logic        u_in_valid;
  logic        u_in_ready;
  logic [15:0] u_in_ascii;
  logic        u_out_valid;
  logic        u_out_ready;
  logic [7:0]  u_out_data;
  logic        u_busy;

  always #5 clk = ~clk;

  hex_line_formatter #(
    .HEX_DIGIT_W(4),
    .NUM_WORDS  (3),
    .SEP        (8'h20),
    .EOL_CRLF   (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ascii (in_ascii),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  hex_line_formatter #(
    .HEX_DIGIT_W(2),
    .NUM_WORDS  (1),
    .SEP        (8'h20),
    .EOL_CRLF   (0)
  ) dut_small (
    .clk      (clk),
    .rst      (rst),
    .in_valid (u_in_valid),
    .in_ready (u_in_ready),
    .in_ascii (u_in_ascii),
    .out_valid(u_out_valid),
    .out_ready(u_out_ready),
    .out_data (u_out_data),
    .busy     (u_busy)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         nbytes;
  int         cyc = 0;
  int         acc_count;
  int         acc_cyc;
  int         first_acc;
  int         last_byte_cyc;
  int         max_gap;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data;
  int         stall;
  logic [7:0] v_exp[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] mk(input string a, input string b, input string c);
    string      s[3];
    logic [95:0] r;
    s[0] = a; s[1] = b; s[2] = c;
    r = '0;
    for (int w = 0; w < 3; w++)
      for (int d = 0; d < 4; d++)
        r[(w*4+d)*8 +: 8] = s[w][3-d];
    return r;
  endfunction

  task automatic push_line(input string a, input string b, input string c);
    string s[3];
    s[0] = a; s[1] = b; s[2] = c;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) sb.push_back(8'(s[w][i]));
      if (w < 2) sb.push_back(8'h20);
    end
    sb.push_back(8'h0D);
    sb.push_back(8'h0A);
  endtask

  // Evaluate the handshakes that the coming clock edge will commit.
  task automatic observe();
    logic [7:0] e;
    if (stall_prev) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(stall_data));
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("extra_byte", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("byte", 32'(out_data), 32'(e));
      end
      if (nbytes > 0 && (cyc - last_byte_cyc) > max_gap) max_gap = cyc - last_byte_cyc;
      last_byte_cyc = cyc;
      nbytes++;
      stall_prev = 1'b0;
    end else begin
      stall_prev = out_valid;
      stall_data = out_data;
    end
    if (in_valid && in_ready) begin
      acc_count++;
      acc_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic cycle(input logic rdy);
    out_ready = rdy;
    #1;
    observe();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_ascii = '0;
    u_in_valid = 1'b0; u_out_ready = 1'b1; u_in_ascii = '0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_small_valid", 32'(u_out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // T1: full-rate line, cycle-accurate
    nbytes = 0; acc_count = 0;
    push_line("1A2F", "0000", "FFFF");
    in_ascii = mk("1A2F", "0000", "FFFF");
    in_valid = 1'b1;
    cycle(1'b1);
    in_valid = 1'b0;
    chk("t1_accept", 32'(acc_count), 32'd1);
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) begin
        chk("t1_in_ready_low", 32'(in_ready), 32'd0);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
      end else begin
        chk("t1_in_ready_back", 32'(in_ready), 32'd1);
        chk("t1_idle_valid", 32'(out_valid), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
      end
      cycle(1'b1);
    end
    chk("t1_count", 32'(nbytes), 32'd16);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // T2: same line with random stalls including 5-cycle holds
    nbytes = 0;
    push_line("1A2F", "0000", "FFFF");
    in_valid = 1'b1;
    cycle(1'b1);
    in_valid = 1'b0;
    stall = 5;
    for (int k = 0; k < 400 && nbytes < 16; k++) begin
      if (stall > 0) begin
        stall--;
        cycle(1'b0);
      end else if ($urandom_range(0, 9) == 0) begin
        stall = 4;
        cycle(1'b0);
      end else begin
        cycle(1'($urandom_range(0, 1)));
      end
    end
    chk("t2_count", 32'(nbytes), 32'd16);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    cycle(1'b1);
    chk("t2_idle", 32'(busy), 32'd0);

    // T3: back-to-back lines with in_valid held
    nbytes = 0; max_gap = 0; acc_count = 0;
    push_line("1A2F", "0000", "FFFF");
    push_line("0001", "0002", "0003");
    in_ascii = mk("1A2F", "0000", "FFFF");
    in_valid = 1'b1;
    cycle(1'b1);
    first_acc = acc_cyc;
    in_ascii = mk("0001", "0002", "0003");
    for (int k = 0; k < 80 && nbytes < 32; k++) begin
      cycle(1'b1);
      if (acc_count == 2) in_valid = 1'b0;
    end
    chk("t3_accepts", 32'(acc_count), 32'd2);
    chk("t3_second_accept_cycle", 32'(acc_cyc - first_acc), 32'd17);
    chk("t3_count", 32'(nbytes), 32'd32);
    chk("t3_max_gap", 32'(max_gap), 32'd2);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    cycle(1'b1);

    // T4: reset after the 7th byte, then a clean line
    nbytes = 0;
    push_line("1A2F", "0000", "FFFF");
    in_ascii = mk("1A2F", "0000", "FFFF");
    in_valid = 1'b1;
    cycle(1'b1);
    in_valid = 1'b0;
    for (int k = 0; k < 30 && nbytes < 7; k++) cycle(1'b1);
    chk("t4_seven", 32'(nbytes), 32'd7);
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_rst_valid", 32'(out_valid), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_data", 32'(out_data), 32'd0);
    chk("t4_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    sb.delete();
    stall_prev = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t4_no_more_bytes", 32'(out_valid), 32'd0);
      cycle(1'b1);
    end
    nbytes = 0;
    push_line("ABCD", "1234", "5678");
    in_ascii = mk("ABCD", "1234", "5678");
    in_valid = 1'b1;
    cycle(1'b1);
    in_valid = 1'b0;
    for (int k = 0; k < 40 && nbytes < 16; k++) cycle(1'b1);
    chk("t4_count", 32'(nbytes), 32'd16);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    cycle(1'b1);

    // T5: in_ascii scrambled every cycle after capture
    nbytes = 0;
    push_line("DEAD", "BEEF", "C0DE");
    in_ascii = mk("DEAD", "BEEF", "C0DE");
    in_valid = 1'b1;
    cycle(1'b1);
    in_valid = 1'b0;
    for (int k = 0; k < 200 && nbytes < 16; k++) begin
      in_ascii = {$urandom, $urandom, $urandom};
      cycle(1'($urandom_range(0, 3) != 0));
    end
    chk("t5_count", 32'(nbytes), 32'd16);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // T6: single-word, two-digit, LF-only variant
    v_exp[0] = 8'h37; v_exp[1] = 8'h45; v_exp[2] = 8'h0A;
    u_in_ascii = 16'h3745;
    u_in_valid = 1'b1;
    chk("t6_ready", 32'(u_in_ready), 32'd1);
    @(posedge clk);
    #1;
    u_in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("t6_valid", 32'(u_out_valid), 32'd1);
      chk("t6_byte", 32'(u_out_data), 32'(v_exp[k-1]));
      chk("t6_in_ready_low", 32'(u_in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("t6_idle_ready", 32'(u_in_ready), 32'd1);
    chk("t6_idle_valid", 32'(u_out_valid), 32'd0);
    chk("t6_idle_busy", 32'(u_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_line_formatter.md
Name: hex_line_formatter

Overview:
Downstream stage of the binary-to-ASCII-hex converters in the accelerometer-to-UART path. It takes one packed set of NUM_WORDS ASCII-hex words (e.g. X/Y/Z axis samples) per transaction and serialises them into a byte stream for the UART transmitter. Each line has the form "WWWW WWWW WWWW\r\n": most-significant digit first, words separated by SEP, line terminated by EOL.

Parameters:
HEX_DIGIT_W, 4, ASCII digits per word; must match the converter instances.
NUM_WORDS, 3, words per line; minimum 1.
SEP, 8'h20, separator byte emitted between words (never after the last word).
EOL_CRLF, 1, 1 = terminate the line with 8'h0D then 8'h0A; 0 = terminate with 8'h0A only.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  in_ascii holds a complete line.
in_ready  out  1  formatter can accept a line.
in_ascii  in  NUM_WORDS*HEX_DIGIT_W*8  byte (w*HEX_DIGIT_W+d) is digit d of word w; d=0 is the least-significant digit.
out_valid  out  1  out_data holds a byte for the UART TX.
out_ready  in  1  UART TX accepts the byte.
out_data  out  8  ASCII byte.
busy  out  1  line in progress (state != IDLE).

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, out_valid=0, out_data=8'h00, busy=0, word/digit counters=0, capture register cleared. in_ready=0 while rst=1.
- in_ready = (state==IDLE) && !rst. It is combinational from state and does not depend on in_valid.
- Accept: on a cycle with in_valid && in_ready, capture in_ascii into an internal register and move to DIGIT with word_idx=0 and digit_idx=HEX_DIGIT_W-1. out_valid rises the next cycle, carrying the first byte.
- Output is registered. While out_valid && !out_ready, out_data and out_valid hold stable. A byte advances only on out_valid && out_ready.
- Byte order: word 0 first. Within a word, digit_idx counts down from HEX_DIGIT_W-1 to 0.
- States and transitions, all taken on an accepted output byte:
  IDLE -> DIGIT on input accept.
  DIGIT: after digit 0 is sent, go to SEP if word_idx < NUM_WORDS-1; otherwise go to CR if EOL_CRLF=1, or LF if EOL_CRLF=0.
  SEP -> DIGIT, with word_idx+1 and digit_idx reset to HEX_DIGIT_W-1.
  CR -> LF.
  LF -> IDLE.
- Line length L = NUM_WORDS*HEX_DIGIT_W + (NUM_WORDS-1) + (EOL_CRLF ? 2 : 1). Default L = 16.
- Throughput with out_ready held high:
  - accept at cycle 0;
  - bytes on cycles 1..L;
  - IDLE and in_ready=1 at cycle L+1;
  - so at most one line every L+1 cycles.
- No overlap: in_ascii changes after capture have no effect on the current line. Upstream must hold in_valid until in_ready; nothing is dropped inside the block.
- out_valid is 0 in IDLE; out_data is don't-care while out_valid=0.
- Input bytes are not checked. Any 8-bit value is passed through unchanged.
- Reset mid-line: the line is abandoned. Outputs return to reset values on the next edge and no further bytes of that line are emitted.
- Counter widths: $clog2 of the range, with a minimum of 1 bit. NUM_WORDS=1 never enters SEP.

Test Plan:
- Default parameters; in_ascii words "1A2F", "0000", "FFFF"; out_ready=1 -> exactly 31 41 32 46 20 30 30 30 30 20 46 46 46 46 0D 0A on cycles 1..16; in_ready=0 on cycles 1..16 and 1 on cycle 17.
- Same line with out_ready toggling pseudo-randomly (including 5-cycle stalls) -> same 16 bytes in order; out_data stable during every stall; no byte duplicated or skipped.
- Two lines with in_valid held continuously, the second being "0001 0002 0003" -> second accept occurs on cycle 17; the full stream is 32 bytes with no gap beyond one idle cycle.
- Assert rst after the 7th accepted byte -> out_valid=0 and busy=0 the next cycle; after release, a new line "ABCD 1234 5678" emits its 16 bytes cleanly.
- Change in_ascii every cycle after accept -> emitted line equals the captured value.
- Parameter variant NUM_WORDS=1, HEX_DIGIT_W=2, EOL_CRLF=0 with input "7E" -> bytes 37 45 0A; no SEP byte; idle on cycle 4.
